result_transmitter: RTL and testbench

//  Sends the product matrix to the host over the UART transmitter after COMPUTE finishes.
//  On start it first sends an optional size header byte.
//  It then reads each N*N result element from the result buffer in row-major order.

---
 rtl/result_transmitter.sv | 196 +++++++++++++++++++
 tb/tb_result_transmitter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_transmitter.sv
// -----------------------------------------------------------------------------
// result_transmitter
//   Streams the N*N result matrix to the host through a byte-wide UART
//   transmitter. An optional header byte {4'h0, N} goes first. Then each
//   element is read from the result buffer in row-major order and sent as
//   RES_W/8 bytes, most significant byte first.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous reset, active high
//   start        1-cycle request; accepted only while idle
//   matrix_size  N, sampled when start is accepted
//   rd_en        result buffer read strobe (data returns one cycle later)
//   rd_addr      result buffer address i*N+j; holds its value between reads
//   rd_data      result buffer read data
//   tx_data      byte for the UART; stable until the next byte is issued
//   tx_start     1-cycle pulse, UART latches tx_data
//   tx_busy      UART busy flag
//   busy         high while a transfer is in progress
//   done         1-cycle pulse once the final byte has left the UART
// -----------------------------------------------------------------------------
module result_transmitter #(
  parameter int RES_W     = 16,
  parameter int ADDR_W    = 8,
  parameter int HEADER_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RES_W-1:0]  rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int NB   = RES_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          n_q, n_d;
  logic [7:0]          total_q, total_d;
  logic [7:0]          elem_cnt_q, elem_cnt_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [NB-1:0][7:0]  shift_q, shift_d;
  logic                hdr_q, hdr_d;        // the byte in flight is the header
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    total_d    = total_q;
    elem_cnt_d = elem_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    hdr_d      = hdr_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = matrix_size;
          // 15*15 = 225 fits in 8 bits, so no overflow is possible
          total_d    = {4'h0, matrix_size} * {4'h0, matrix_size};
          elem_cnt_d = 8'd0;
          busy_d     = 1'b1;
          if (HEADER_EN != 0) begin
            hdr_d   = 1'b1;
            state_d = S_HDR;
          end else if (matrix_size == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HDR: begin
        if (!tx_busy) begin
          tx_data_d  = {4'h0, n_q};
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // rd_en was high during FETCH, so rd_data is valid this cycle
        shift_d    = rd_data;
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = shift_q[BI_W'(NB-1) - byte_idx_q];
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = (n_q == 4'd0) ? S_DONE : S_FETCH;
          end else if (byte_idx_q != BI_W'(NB-1)) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_SEND;
          end else if (elem_cnt_q == total_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            elem_cnt_d = elem_cnt_q + 8'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The read strobe is registered, so it is raised on entry to FETCH; the
    // buffer then sees it during FETCH and returns data during LOAD.
    if (state_d == S_FETCH) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ADDR_W'(elem_cnt_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      total_q    <= '0;
      elem_cnt_q <= '0;
      byte_idx_q <= '0;
      // NOTE: the shift register is reset too so a stale element can never
      // reach tx_data after an aborted transfer.
      shift_q    <= '0;
      hdr_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      total_q    <= total_d;
      elem_cnt_q <= elem_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      hdr_q      <= hdr_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_result_transmitter.sv
// -----------------------------------------------------------------------------
// tb_result_transmitter
//   Three instances share one clock:
//     0: RES_W=16, header on    1: RES_W=16, header off    2: RES_W=32, header on
//   Each has a buffer model (1-cycle read latency) and a UART model whose busy
//   flag rises the cycle after tx_start and stays up for a fixed time; the
//   bench may also force busy high to create stalls.
//   The expected byte stream for a transfer is built from the buffer contents
//   (header, then each element MSB first). A negedge compare process checks
//   every tx_start byte, every read address and the handshake rule.
// -----------------------------------------------------------------------------
module tb_result_transmitter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start  [NI];
  logic [3:0]  msize  [NI];
  logic        rd_en  [NI];
  logic [7:0]  rd_addr[NI];
  logic [15:0] rd16   [2];
  logic [31:0] rd32;
  logic [7:0]  tx_data[NI];
  logic        tx_start[NI];
  logic        tx_busy[NI];
  logic        busy   [NI];
  logic        done   [NI];
  logic        hold   [NI];

  result_transmitter #(.RES_W(16), .ADDR_W(8), .HEADER_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .matrix_size(msize[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd16[0]),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
    .busy(busy[0]), .done(done[0]));

  result_transmitter #(.RES_W(16), .ADDR_W(8), .HEADER_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .matrix_size(msize[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd16[1]),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
    .busy(busy[1]), .done(done[1]));

  result_transmitter #(.RES_W(32), .ADDR_W(8), .HEADER_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .matrix_size(msize[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd32),
    .tx_data(tx_data[2]), .tx_start(tx_start[2]), .tx_busy(tx_busy[2]),
    .busy(busy[2]), .done(done[2]));

  // ---------------- buffer and UART models ----------------
  logic [31:0] mem[NI][256];

  always @(posedge clk) begin
    if (rd_en[0]) rd16[0] <= mem[0][rd_addr[0]][15:0];
    if (rd_en[1]) rd16[1] <= mem[1][rd_addr[1]][15:0];
    if (rd_en[2]) rd32    <= mem[2][rd_addr[2]];
  end

  int ucnt[NI] = '{default: 0};
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (tx_start[k])      ucnt[k] <= 3 + k;
      else if (ucnt[k] != 0) ucnt[k] <= ucnt[k] - 1;
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) tx_busy[k] = (ucnt[k] != 0) || hold[k];
  end

  // ---------------- checking ----------------
  int total_chk = 0;
  int bad_chk   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_chk++;
    if (act !== exp) begin
      bad_chk++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream (owned by the stimulus process)
  logic [7:0] exp_b[NI][1024];
  int         exp_n  [NI] = '{default: 0};
  int         rd_base[NI] = '{default: 0};
  int         exp_rd [NI] = '{default: 0};

  // Observed activity (owned by the compare process)
  logic [7:0] got_b[NI][1024];
  int         got_n    [NI] = '{default: 0};
  int         rd_cnt   [NI] = '{default: 0};
  int         done_cnt [NI] = '{default: 0};
  logic [7:0] last_addr[NI] = '{default: 8'h00};

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if (tx_start[k]) begin
          check("tx_start_while_busy", 32'(tx_busy[k]), 32'd0);
          check("busy_during_tx", 32'(busy[k]), 32'd1);
          if (got_n[k] < exp_n[k] && got_n[k] < 1024)
            check("tx_byte", 32'(tx_data[k]), 32'(exp_b[k][got_n[k]]));
          else
            check("extra_tx_byte", 32'(got_n[k]), 32'(exp_n[k]));
          if (got_n[k] < 1024) got_b[k][got_n[k]] <= tx_data[k];
          got_n[k] <= got_n[k] + 1;
        end
        if (rd_en[k]) begin
          check("rd_addr", 32'(rd_addr[k]), 32'(rd_cnt[k] - rd_base[k]));
          rd_cnt[k]    <= rd_cnt[k] + 1;
          last_addr[k] <= rd_addr[k];
        end
        if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_xfer(input int k, input logic [3:0] n);
    int nb;
    nb = (k == 2) ? 4 : 2;
    rd_base[k] = rd_cnt[k];
    exp_rd[k]  = int'(n) * int'(n);
    if (k != 1) begin
      exp_b[k][exp_n[k]] = {4'h0, n};
      exp_n[k]++;
    end
    for (int e = 0; e < int'(n) * int'(n); e++) begin
      for (int b = nb - 1; b >= 0; b--) begin
        exp_b[k][exp_n[k]] = mem[k][e][b*8 +: 8];
        exp_n[k]++;
      end
    end
    @(posedge clk); #1;
    start[k] = 1'b1;
    msize[k] = n;
    @(posedge clk); #1;
    start[k] = 1'b0;
    msize[k] = 4'h9;   // garbage: N must have been sampled already
  endtask

  task automatic wait_done(input int k, input string name, input int budget);
    int d0;
    int i;
    d0 = done_cnt[k];
    i  = 0;
    while (done_cnt[k] == d0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_done_seen"}, 32'(done_cnt[k] != d0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_byte_count"}, 32'(got_n[k]), 32'(exp_n[k]));
    check({name, "_read_count"}, 32'(rd_cnt[k] - rd_base[k]), 32'(exp_rd[k]));
    check({name, "_single_done"}, 32'(done_cnt[k] - d0), 32'd1);
    check({name, "_idle_busy"}, 32'(busy[k]), 32'd0);
  endtask

  task automatic wait_got(input int k, input int target, input string name);
    int i;
    i = 0;
    while (got_n[k] < target && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_reached"}, 32'(got_n[k] >= target), 32'd1);
  endtask

  task automatic check_t1_stream(input int base, input string name);
    logic [7:0] lit[9];
    lit = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 9; i++)
      check({name, "_literal_byte"}, 32'(got_b[0][base + i]), 32'(lit[i]));
    check({name, "_last_addr"}, 32'(last_addr[0]), 32'd3);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int s0;
    int d0;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0;
      msize[k] = 4'h0;
      hold[k]  = 1'b0;
      for (int e = 0; e < 256; e++) mem[k][e] = 32'h0;
    end
    mem[0][0] = 32'h0102; mem[0][1] = 32'h0304;
    mem[0][2] = 32'h0506; mem[0][3] = 32'h0708;
    mem[1][0] = 32'h0102; mem[1][1] = 32'h0304;
    mem[1][2] = 32'h0506; mem[1][3] = 32'h0708;
    for (int e = 0; e < 256; e++) begin
      mem[2][e] = {8'(e), ~8'(e), 8'(e) + 8'h5a, 8'(e) ^ 8'hc3};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("reset_rd_en",    32'(rd_en[k]),    32'd0);
      check("reset_rd_addr",  32'(rd_addr[k]),  32'd0);
      check("reset_tx_data",  32'(tx_data[k]),  32'd0);
      check("reset_tx_start", 32'(tx_start[k]), 32'd0);
      check("reset_busy",     32'(busy[k]),     32'd0);
      check("reset_done",     32'(done[k]),     32'd0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: basic N=2 stream with header
    base = got_n[0];
    begin_xfer(0, 4'd2);
    wait_done(0, "t1", 2000);
    check_t1_stream(base, "t1");

    // T2: N=0 with header -> one 0x00 byte, no reads
    base = got_n[0];
    begin_xfer(0, 4'd0);
    wait_done(0, "t2_hdr", 500);
    check("t2_hdr_byte", 32'(got_b[0][base]), 32'h00);
    check("t2_hdr_one_byte", 32'(got_n[0] - base), 32'd1);

    // T2: N=0 without header -> done two cycles after start, no tx_start
    d0 = done_cnt[1];
    s0 = got_n[1];
    begin_xfer(1, 4'd0);
    check("t2_nohdr_busy_c1", 32'(busy[1]), 32'd1);
    check("t2_nohdr_done_c1", 32'(done[1]), 32'd0);
    @(posedge clk); #1;
    check("t2_nohdr_done_c2", 32'(done[1]), 32'd1);
    check("t2_nohdr_busy_c2", 32'(busy[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_nohdr_one_done", 32'(done_cnt[1] - d0), 32'd1);
    check("t2_nohdr_no_tx", 32'(got_n[1] - s0), 32'd0);

    // No-header N=2 stream: starts directly with the first element's MSB
    base = got_n[1];
    begin_xfer(1, 4'd2);
    wait_done(1, "nohdr", 2000);
    check("nohdr_first_byte", 32'(got_b[1][base]), 32'h01);
    check("nohdr_byte_total", 32'(got_n[1] - base), 32'd8);

    // T3: long UART stall right after the header
    base = got_n[0];
    begin_xfer(0, 4'd2);
    wait_got(0, base + 1, "t3_header");
    hold[0] = 1'b1;
    s0 = got_n[0];
    repeat (50) @(posedge clk);
    #1;
    check("t3_no_tx_in_stall", 32'(got_n[0] - s0), 32'd0);
    hold[0] = 1'b0;
    wait_done(0, "t3", 2000);
    check_t1_stream(base, "t3");

    // T4: second start mid-transfer with a different size is ignored
    base = got_n[0];
    begin_xfer(0, 4'd2);
    repeat (10) @(posedge clk);
    #1;
    start[0] = 1'b1;
    msize[0] = 4'd5;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, "t4", 2000);
    check_t1_stream(base, "t4");

    // T5: reset during the third data byte, then a clean restart
    base = got_n[0];
    d0 = done_cnt[0];
    begin_xfer(0, 4'd2);
    wait_got(0, base + 4, "t5_third_byte");
    rst = 1'b1;
    #1;
    check("t5_rst_rd_en",    32'(rd_en[0]),    32'd0);
    check("t5_rst_rd_addr",  32'(rd_addr[0]),  32'd0);
    check("t5_rst_tx_data",  32'(tx_data[0]),  32'd0);
    check("t5_rst_tx_start", 32'(tx_start[0]), 32'd0);
    check("t5_rst_busy",     32'(busy[0]),     32'd0);
    check("t5_rst_done",     32'(done[0]),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_n[0] = got_n[0];
    s0 = got_n[0];
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_tx_after_abort", 32'(got_n[0] - s0), 32'd0);
    check("t5_no_done_after_abort", 32'(done_cnt[0] - d0), 32'd0);
    base = got_n[0];
    begin_xfer(0, 4'd2);
    wait_done(0, "t5", 2000);
    check_t1_stream(base, "t5");

    // T6: N=15, 32-bit elements
    base = got_n[2];
    begin_xfer(2, 4'd15);
    wait_done(2, "t6", 20000);
    check("t6_byte_total", 32'(got_n[2] - base), 32'd901);
    check("t6_last_addr", 32'(last_addr[2]), 32'd224);
    check("t6_header", 32'(got_b[2][base]), 32'h0f);
    check("t6_first_b0", 32'(got_b[2][base + 1]), 32'h00);
    check("t6_first_b1", 32'(got_b[2][base + 2]), 32'hff);
    check("t6_first_b2", 32'(got_b[2][base + 3]), 32'h5a);
    check("t6_first_b3", 32'(got_b[2][base + 4]), 32'hc3);
    check("t6_last_b0", 32'(got_b[2][base + 897]), 32'he0);
    check("t6_last_b1", 32'(got_b[2][base + 898]), 32'h1f);
    check("t6_last_b2", 32'(got_b[2][base + 899]), 32'h3a);
    check("t6_last_b3", 32'(got_b[2][base + 900]), 32'h23);

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
